bias_mem_stream: RTL and testbench

- Parametrised successor to the fixed 19-entry bias register bank. Depth and width are generalised.
- Biases are loaded serially over a valid/ready stream, not as 19 parallel buses.
- Reads go through a registered, range-checked port with a valid flag.
- Sits between the host/config loader and the layer datapath (MAC + bias add), which reads one bias per output neuron.

---
 rtl/bias_mem_pkg.sv | 26 ++
 rtl/bias_mem_stream_if.sv | 46 ++++
 rtl/bias_ld_fsm.sv | 94 +++++++++
 rtl/bias_mem_stream.sv | 116 +++++++++++
 tb/tb_bias_mem_stream.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bias_mem_pkg.sv
//==============================================================================
// Module : bias_mem_pkg
// Brief  : Shared types and defaults for the streamed bias memory.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package bias_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } ld_state_t;

  localparam int c_DEF_DATA_W = 32;
  localparam int c_DEF_DEPTH  = 19;
  localparam int c_DEF_ADDR_W = 5;

  function automatic bit addr_w_fits(input int depth, input int addr_w);
    return addr_w >= $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bias_mem_stream_if.sv
//==============================================================================
// Module : bias_mem_stream_if
// Brief  : Load stream and read port bundle; Par_err exists only with BIAS_MEM_PARITY_EN.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface bias_mem_stream_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              Ld_start;
  logic              Ld_valid;
  logic [DATA_W-1:0] Ld_data;
  logic              Ld_ready;
  logic              Ld_done;
  logic              Loaded;
  logic              Rd_en;
  logic [ADDR_W-1:0] Rd_addr;
  logic [DATA_W-1:0] Rd_data;
  logic              Rd_valid;
  logic              Rd_err;
`ifdef BIAS_MEM_PARITY_EN
  logic              Par_err;

  modport master (
    output Ld_start, Ld_valid, Ld_data, Rd_en, Rd_addr,
    input  Ld_ready, Ld_done, Loaded, Rd_data, Rd_valid, Rd_err, Par_err
  );
  modport slave (
    input  Ld_start, Ld_valid, Ld_data, Rd_en, Rd_addr,
    output Ld_ready, Ld_done, Loaded, Rd_data, Rd_valid, Rd_err, Par_err
  );
`else
  modport master (
    output Ld_start, Ld_valid, Ld_data, Rd_en, Rd_addr,
    input  Ld_ready, Ld_done, Loaded, Rd_data, Rd_valid, Rd_err
  );
  modport slave (
    input  Ld_start, Ld_valid, Ld_data, Rd_en, Rd_addr,
    output Ld_ready, Ld_done, Loaded, Rd_data, Rd_valid, Rd_err
  );
`endif
endinterface

`default_nettype wire

// File: rtl/bias_ld_fsm.sv
//==============================================================================
// Module : bias_ld_fsm
// Brief  : Load sequencer: owns state, write pointer, Ld_ready/Ld_done/Loaded.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bias_ld_fsm
  import bias_mem_pkg::*;
#(
  parameter int DEPTH  = c_DEF_DEPTH,
  parameter int ADDR_W = c_DEF_ADDR_W
) (
  input  logic              Clock,
  input  logic              Res,
  input  logic              ld_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              loaded,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr
);

  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);

  ld_state_t         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic              r_done, w_done_nxt;
  logic              r_loaded;

  always_ff @(posedge Clock or posedge Res) begin
    if (Res) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_done   <= 1'b0;
      r_loaded <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_done   <= w_done_nxt;
      r_loaded <= (w_state_nxt == READY);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_done_nxt  = 1'b0;
    wr_en       = 1'b0;
    ld_ready    = 1'b0;
    case (r_state)
      IDLE: begin
        if (ld_start) begin
          w_state_nxt = LOAD;
          w_ptr_nxt   = '0;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        // A restart wins over a word presented in the same cycle.
        if (ld_start) begin
          w_ptr_nxt = '0;
        end else if (ld_valid) begin
          wr_en = 1'b1;
          if (r_ptr == c_LAST) begin
            w_state_nxt = READY;
            w_ptr_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_ptr_nxt = r_ptr + 1'b1;
          end
        end
      end
      READY: begin
        if (ld_start) begin
          w_state_nxt = LOAD;
          w_ptr_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  assign wr_addr = r_ptr;
  assign ld_done = r_done;
  assign loaded  = r_loaded;

endmodule

`default_nettype wire

// File: rtl/bias_mem_stream.sv
//==============================================================================
// Module : bias_mem_stream
// Brief  : Serially loaded bias table with a registered, range-checked read port.
//          Optional macro BIAS_MEM_PARITY_EN adds per-entry even parity and Par_err.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bias_mem_stream
  import bias_mem_pkg::*;
#(
  parameter int DATA_W = c_DEF_DATA_W,
  parameter int DEPTH  = c_DEF_DEPTH,
  parameter int ADDR_W = c_DEF_ADDR_W
) (
  input  logic              Clock,
  input  logic              Res,
  bias_mem_stream_if.slave  bus
);

  generate
    if (!addr_w_fits(DEPTH, ADDR_W)) begin : g_addr_w_bad
      $error("bias_mem_stream: ADDR_W too small for DEPTH");
    end
  endgenerate

`ifdef BIAS_MEM_PARITY_EN
  localparam int c_MEM_W = DATA_W + 1;
`else
  localparam int c_MEM_W = DATA_W;
`endif

  logic [c_MEM_W-1:0] r_mem [DEPTH];
  logic               w_wr_en;
  logic [ADDR_W-1:0]  w_wr_addr;
  logic [c_MEM_W-1:0] w_wr_word;
  logic [c_MEM_W-1:0] w_rd_word;
  logic               w_loaded;
  logic               w_rd_ok;
  logic [DATA_W-1:0]  r_rd_data;
  logic               r_rd_valid;
  logic               r_rd_err;

  bias_ld_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ld_fsm (
    .Clock    (Clock),
    .Res      (Res),
    .ld_start (bus.Ld_start),
    .ld_valid (bus.Ld_valid),
    .ld_ready (bus.Ld_ready),
    .ld_done  (bus.Ld_done),
    .loaded   (w_loaded),
    .wr_en    (w_wr_en),
    .wr_addr  (w_wr_addr)
  );

`ifdef BIAS_MEM_PARITY_EN
  assign w_wr_word = {^bus.Ld_data, bus.Ld_data};
`else
  assign w_wr_word = bus.Ld_data;
`endif

  always_ff @(posedge Clock or posedge Res) begin
    if (Res) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[w_wr_addr] <= w_wr_word;
    end
  end

  // Writes only happen while Loaded is low, so reads never see a same-cycle write.
  assign w_rd_ok   = w_loaded && ({1'b0, bus.Rd_addr} < (ADDR_W + 1)'(DEPTH));
  assign w_rd_word = r_mem[bus.Rd_addr];

  always_ff @(posedge Clock or posedge Res) begin
    if (Res) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end else if (bus.Rd_en) begin
      r_rd_valid <= w_rd_ok;
      r_rd_err   <= !w_rd_ok;
      r_rd_data  <= w_rd_ok ? w_rd_word[DATA_W-1:0] : '0;
    end else begin
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end
  end

`ifdef BIAS_MEM_PARITY_EN
  logic r_par_err;

  // Stored word plus parity bit XORs to 1 exactly when the entry is corrupted.
  always_ff @(posedge Clock or posedge Res) begin
    if (Res) begin
      r_par_err <= 1'b0;
    end else begin
      r_par_err <= bus.Rd_en && w_rd_ok && (^w_rd_word);
    end
  end

  assign bus.Par_err = r_par_err;
`endif

  assign bus.Loaded   = w_loaded;
  assign bus.Rd_data  = r_rd_data;
  assign bus.Rd_valid = r_rd_valid;
  assign bus.Rd_err   = r_rd_err;

endmodule

`default_nettype wire

// File: tb/tb_bias_mem_stream.sv
//==============================================================================
// Module : tb_bias_mem_stream
// Brief  : Scoreboard bench for bias_mem_stream (loads, read errors, restart, reset).
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bias_mem_stream;

  localparam int c_DEPTH = 19;

  typedef struct {
    logic [31:0] data;
    logic        valid;
    logic        err;
    logic        par;
  } rd_exp_t;

  logic Clock;
  logic Res;
  int   n_checks;
  int   n_errors;
  int   ready_cnt;
  int   done_cnt;
  logic rd_pending;
  logic model_loaded;
  logic [31:0] exp_mem  [c_DEPTH];
  logic        par_flip [c_DEPTH];
  logic [31:0] stim     [c_DEPTH];
  rd_exp_t     sb[$];

  bias_mem_stream_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  bias_mem_stream #(.DATA_W(32), .DEPTH(c_DEPTH), .ADDR_W(5)) dut (
    .Clock (Clock),
    .Res   (Res),
    .bus   (bus)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rd_pending = 1'b0;
    forever begin
      @(posedge Clock);
      rd_pending = bus.Rd_en;
    end
  end

  initial begin
    rd_exp_t e;
    ready_cnt = 0;
    done_cnt  = 0;
    forever begin
      @(negedge Clock);
      if (bus.Ld_ready) ready_cnt++;
      if (bus.Ld_done)  done_cnt++;
      if (rd_pending) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("rd_valid", bus.Rd_valid, e.valid);
          chk("rd_err",   bus.Rd_err,   e.err);
          chk("rd_data",  bus.Rd_data,  e.data);
`ifdef BIAS_MEM_PARITY_EN
          chk("par_err",  bus.Par_err,  e.par);
`endif
        end
      end
    end
  end

  // All tasks are entered right after a falling edge.
  task automatic issue_read(input logic [4:0] addr);
    rd_exp_t e;
    if (model_loaded && addr < c_DEPTH) begin
      e.data = exp_mem[addr]; e.valid = 1'b1; e.err = 1'b0; e.par = par_flip[addr];
    end else begin
      e.data = '0; e.valid = 1'b0; e.err = 1'b1; e.par = 1'b0;
    end
    sb.push_back(e);
    bus.Rd_en   = 1'b1;
    bus.Rd_addr = addr;
  endtask

  task automatic read_one(input logic [4:0] addr);
    issue_read(addr);
    @(negedge Clock);
    bus.Rd_en = 1'b0;
    @(negedge Clock);
  endtask

  task automatic start_load();
    bus.Ld_start = 1'b1;
    @(negedge Clock);
    bus.Ld_start = 1'b0;
    model_loaded = 1'b0;
  endtask

  task automatic stream(input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      bus.Ld_valid = 1'b1;
      bus.Ld_data  = stim[i];
      chk("ld_ready", bus.Ld_ready, 1);
      @(negedge Clock);
      exp_mem[i] = stim[i];
      if (toggle && i < n - 1) begin
        bus.Ld_valid = 1'b0;
        bus.Ld_data  = ~stim[i];
        @(negedge Clock);
      end
    end
    bus.Ld_valid = 1'b0;
    if (n == c_DEPTH) model_loaded = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_loaded = 1'b0;
    for (int i = 0; i < c_DEPTH; i++) begin
      exp_mem[i] = '0; par_flip[i] = 1'b0;
    end
    Res = 1'b1;
    bus.Ld_start = 1'b0; bus.Ld_valid = 1'b0; bus.Ld_data = '0;
    bus.Rd_en = 1'b0; bus.Rd_addr = '0;
    repeat (3) @(negedge Clock);
    chk("rst_ld_ready", bus.Ld_ready, 0);
    chk("rst_ld_done",  bus.Ld_done,  0);
    chk("rst_loaded",   bus.Loaded,   0);
    chk("rst_rd_valid", bus.Rd_valid, 0);
    chk("rst_rd_err",   bus.Rd_err,   0);
    chk("rst_rd_data",  bus.Rd_data,  0);
    Res = 1'b0;
    @(negedge Clock);

    read_one(5'd3);

    // Continuous load of 1..19, then one extra word that must be dropped.
    for (int i = 0; i < c_DEPTH; i++) stim[i] = 32'(i + 1);
    ready_cnt = 0; done_cnt = 0;
    start_load();
    stream(c_DEPTH, 1'b0);
    bus.Ld_valid = 1'b1; bus.Ld_data = 32'hDEAD_BEEF;
    chk("ld_done_pulse", bus.Ld_done, 1);
    chk("loaded_set",    bus.Loaded,  1);
    @(negedge Clock);
    bus.Ld_valid = 1'b0;
    chk("ld_done_clear", bus.Ld_done, 0);
    chk("ready_cycles",  ready_cnt, 19);
    chk("done_count",    done_cnt,  1);
    issue_read(5'd0);
    @(negedge Clock);
    issue_read(5'd18);
    @(negedge Clock);
    bus.Rd_en = 1'b0;
    @(negedge Clock);
    read_one(5'd19);
    read_one(5'd31);

    // Gapped load of negative values.
    for (int i = 0; i < c_DEPTH; i++) stim[i] = 32'(-10 - i);
    done_cnt = 0;
    start_load();
    stream(c_DEPTH, 1'b1);
    @(negedge Clock);
    chk("done_count_gap", done_cnt, 1);
    read_one(5'd0);
    read_one(5'd9);
    read_one(5'd18);

    // Restart after 7 words; the word presented with the restart is ignored.
    for (int i = 0; i < c_DEPTH; i++) stim[i] = 32'h100 + 32'(i);
    start_load();
    stream(7, 1'b0);
    chk("loaded_midload", bus.Loaded, 0);
    bus.Ld_start = 1'b1; bus.Ld_valid = 1'b1; bus.Ld_data = 32'h0000_0BAD;
    @(negedge Clock);
    bus.Ld_start = 1'b0; bus.Ld_valid = 1'b0;
    for (int i = 0; i < c_DEPTH; i++) stim[i] = 32'h200 + 32'(i);
    stream(c_DEPTH, 1'b0);
    read_one(5'd0);
    read_one(5'd6);
    read_one(5'd7);
    read_one(5'd18);

    // Asynchronous reset after 10 words discards everything.
    for (int i = 0; i < c_DEPTH; i++) stim[i] = 32'h300 + 32'(i);
    start_load();
    stream(10, 1'b0);
    #2 Res = 1'b1;
    for (int i = 0; i < c_DEPTH; i++) exp_mem[i] = '0;
    model_loaded = 1'b0;
    #2;
    chk("res_ld_ready", bus.Ld_ready, 0);
    chk("res_loaded",   bus.Loaded,   0);
    chk("res_rd_data",  bus.Rd_data,  0);
    chk("res_rd_valid", bus.Rd_valid, 0);
    @(negedge Clock);
    Res = 1'b0;
    @(negedge Clock);
    read_one(5'd2);
    for (int i = 0; i < c_DEPTH; i++) stim[i] = '0;
    start_load();
    stream(c_DEPTH, 1'b0);
    read_one(5'd0);
    read_one(5'd9);

    // Ld_start and a read together in READY.
    for (int i = 0; i < c_DEPTH; i++) stim[i] = 32'h400 + 32'(i);
    start_load();
    stream(c_DEPTH, 1'b0);
    bus.Ld_start = 1'b1;
    issue_read(5'd5);
    model_loaded = 1'b0;
    @(negedge Clock);
    bus.Ld_start = 1'b0; bus.Rd_en = 1'b0;
    chk("loaded_drop", bus.Loaded,   0);
    chk("ready_again", bus.Ld_ready, 1);
    @(negedge Clock);
    read_one(5'd5);
    for (int i = 0; i < c_DEPTH; i++) stim[i] = 32'h500 + 32'(i);
    stream(c_DEPTH, 1'b0);
    read_one(5'd5);

`ifdef BIAS_MEM_PARITY_EN
    dut.r_mem[5][0] = ~dut.r_mem[5][0];
    exp_mem[5][0]   = ~exp_mem[5][0];
    par_flip[5]     = 1'b1;
    read_one(5'd5);
    read_one(5'd6);
`endif

    @(negedge Clock);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
